// File: rtl/s_div_arbiter.sv
// s_div_arbiter: round-robin front end that shares one iterative divide unit
// among N_REQ streaming requesters. One transaction is in flight at a time;
// every state change is gated by the global pea_ready_i stall.

package s_div_arbiter_pkg;
    typedef enum logic [3:0] {
        FU_NOP    = 4'd0,
        FU_ADD    = 4'd1,
        FU_SUB    = 4'd2,
        FU_MUL    = 4'd3,
        FU_ACC    = 4'd4,
        FU_DIV    = 4'd5,
        FU_REM    = 4'd6,
        FU_ABSDIV = 4'd7,
        FU_ABSREM = 4'd8
    } fu_instr_t;

    function automatic logic is_div_op(input fu_instr_t op);
        return (op == FU_DIV) || (op == FU_REM) || (op == FU_ABSDIV) || (op == FU_ABSREM);
    endfunction
endpackage

module s_div_arbiter
    import s_div_arbiter_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int N_BITS = 32,
    parameter int IDX_W  = $clog2(N_REQ)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          pea_ready_i,
    input  logic [N_REQ-1:0]              req_valid_i,
    output logic [N_REQ-1:0]              req_ready_o,
    input  logic [N_REQ-1:0][N_BITS-1:0]  req_a_i,
    input  logic [N_REQ-1:0][N_BITS-1:0]  req_b_i,
    input  fu_instr_t [N_REQ-1:0]         req_instr_i,
    output logic                          div_valid_o,
    input  logic                          div_ready_i,
    output logic [N_BITS-1:0]             div_a_o,
    output logic [N_BITS-1:0]             div_b_o,
    output fu_instr_t                     div_instr_o,
    input  logic                          div_valid_i,
    input  logic [N_BITS-1:0]             div_res_i,
    input  logic [N_BITS-1:0]             div_rem_q_i,
    output logic [N_REQ-1:0]              rsp_valid_o,
    input  logic [N_REQ-1:0]              rsp_ready_i,
    output logic [N_BITS-1:0]             rsp_res_o,
    output logic [N_BITS-1:0]             rsp_rem_q_o,
    output logic                          rsp_err_o,
    output logic                          busy_o,
    output logic [IDX_W-1:0]              grant_idx_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]        state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  grant_q;
    logic [N_BITS-1:0] a_q;
    logic [N_BITS-1:0] b_q;
    fu_instr_t         instr_q;
    logic [N_BITS-1:0] res_q;
    logic [N_BITS-1:0] rem_q_q;
    logic              err_q;

    logic              found;
    logic [IDX_W-1:0]  pick;
    logic [IDX_W-1:0]  cand;
    int                idx_sum;
    logic              accept;
    logic              issue_done;
    logic              div_done;
    logic              rsp_done;
    logic [IDX_W-1:0]  next_ptr;

    // Round-robin scan: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write,
        // otherwise the tool infers a latch to hold the old value.
        found   = 1'b0;
        pick    = '0;
        cand    = '0;
        idx_sum = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx_sum = int'(rr_ptr) + i;
            if (idx_sum >= N_REQ) idx_sum = idx_sum - N_REQ;
            cand = IDX_W'(idx_sum);
            if (!found && req_valid_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign accept     = (state == S_IDLE) && pea_ready_i && found;
    assign issue_done = (state == S_ISSUE) && pea_ready_i && div_ready_i;
    assign div_done   = (state == S_WAIT) && pea_ready_i && div_valid_i;
    assign rsp_done   = (state == S_RESP) && pea_ready_i && rsp_ready_i[grant_q];
    assign next_ptr   = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;

    // One-hot handshake strobes toward requesters; quiet while reset is held.
    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        if (accept && rst_n_i) req_ready_o[pick] = 1'b1;
        if (state == S_RESP)   rsp_valid_o[grant_q] = 1'b1;
    end

    assign div_valid_o = (state == S_ISSUE);
    assign div_a_o     = a_q;
    assign div_b_o     = b_q;
    assign div_instr_o = instr_q;
    assign rsp_res_o   = res_q;
    assign rsp_rem_q_o = rem_q_q;
    assign rsp_err_o   = err_q;
    assign busy_o      = (state != S_IDLE);
    assign grant_idx_o = grant_q;

    // Transaction FSM, round-robin pointer, owner and latched operands.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= S_IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            instr_q <= FU_NOP;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        grant_q <= pick;
                        a_q     <= req_a_i[pick];
                        b_q     <= req_b_i[pick];
                        instr_q <= req_instr_i[pick];
                        state   <= is_div_op(req_instr_i[pick]) ? S_ISSUE : S_RESP;
                    end
                end
                S_ISSUE: if (issue_done) state <= S_WAIT;
                S_WAIT:  if (div_done)   state <= S_RESP;
                S_RESP: begin
                    if (rsp_done) begin
                        rr_ptr <= next_ptr;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Response payload: divider result, or zeros plus error for non-divide ops.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            res_q   <= '0;
            rem_q_q <= '0;
            err_q   <= 1'b0;
        end else if (accept && !is_div_op(req_instr_i[pick])) begin
            res_q   <= '0;
            rem_q_q <= '0;
            err_q   <= 1'b1;
        end else if (div_done) begin
            res_q   <= div_res_i;
            rem_q_q <= div_rem_q_i;
            err_q   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_s_div_arbiter.sv
// Directed bench for s_div_arbiter: reset, single divide, round-robin
// fairness, illegal-op bypass, stalls in each phase, back-pressure and
// reset during a pending divide.

module tb_s_div_arbiter;
    import s_div_arbiter_pkg::*;

    logic              clk_i;
    logic              rst_n_i;
    logic              pea_ready_i;
    logic [3:0]        req_valid_i;
    logic [3:0]        req_ready_o;
    logic [3:0][31:0]  req_a_i;
    logic [3:0][31:0]  req_b_i;
    fu_instr_t [3:0]   req_instr_i;
    logic              div_valid_o;
    logic              div_ready_i;
    logic [31:0]       div_a_o;
    logic [31:0]       div_b_o;
    fu_instr_t         div_instr_o;
    logic              div_valid_i;
    logic [31:0]       div_res_i;
    logic [31:0]       div_rem_q_i;
    logic [3:0]        rsp_valid_o;
    logic [3:0]        rsp_ready_i;
    logic [31:0]       rsp_res_o;
    logic [31:0]       rsp_rem_q_o;
    logic              rsp_err_o;
    logic              busy_o;
    logic [1:0]        grant_idx_o;

    int total = 0;
    int bad   = 0;

    s_div_arbiter #(.N_REQ(4), .N_BITS(32)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .pea_ready_i(pea_ready_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_instr_i(req_instr_i),
        .div_valid_o(div_valid_o), .div_ready_i(div_ready_i),
        .div_a_o(div_a_o), .div_b_o(div_b_o), .div_instr_o(div_instr_o),
        .div_valid_i(div_valid_i), .div_res_i(div_res_i), .div_rem_q_i(div_rem_q_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_res_o(rsp_res_o), .rsp_rem_q_o(rsp_rem_q_o), .rsp_err_o(rsp_err_o),
        .busy_o(busy_o), .grant_idx_o(grant_idx_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Full unstalled divide transaction for owner g; divider answers res/rem.
    task automatic do_div(input int g, input logic [31:0] ea, input logic [31:0] eb,
                          input logic [31:0] res, input logic [31:0] rem);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        #1;
        check("accept_ready", 64'(req_ready_o), 64'(oh));
        tick();
        check("issue_valid", 64'(div_valid_o), 64'd1);
        check("issue_a", 64'(div_a_o), 64'(ea));
        check("issue_b", 64'(div_b_o), 64'(eb));
        check("issue_grant", 64'(grant_idx_o), 64'(g));
        check("issue_no_ready", 64'(req_ready_o), 64'd0);
        div_ready_i = 1'b1;
        tick();
        div_ready_i = 1'b0;
        check("wait_no_valid", 64'(div_valid_o), 64'd0);
        check("wait_busy", 64'(busy_o), 64'd1);
        div_valid_i = 1'b1;
        div_res_i   = res;
        div_rem_q_i = rem;
        tick();
        div_valid_i = 1'b0;
        check("rsp_valid", 64'(rsp_valid_o), 64'(oh));
        check("rsp_res", 64'(rsp_res_o), 64'(res));
        check("rsp_rem", 64'(rsp_rem_q_o), 64'(rem));
        check("rsp_err", 64'(rsp_err_o), 64'd0);
        rsp_ready_i = oh;
        tick();
        rsp_ready_i = 4'b0;
        check("idle_busy", 64'(busy_o), 64'd0);
        check("idle_rsp_valid", 64'(rsp_valid_o), 64'd0);
    endtask

    initial begin
        rst_n_i     = 1'b0;
        pea_ready_i = 1'b1;
        req_valid_i = 4'b0;
        div_ready_i = 1'b0;
        div_valid_i = 1'b0;
        div_res_i   = '0;
        div_rem_q_i = '0;
        rsp_ready_i = 4'b0;
        for (int i = 0; i < 4; i++) begin
            req_a_i[i]     = 32'(100 + 10 * i);
            req_b_i[i]     = 32'(i + 1);
            req_instr_i[i] = FU_DIV;
        end

        // Reset state
        #12;
        check("rst_req_ready", 64'(req_ready_o), 64'd0);
        check("rst_div_valid", 64'(div_valid_o), 64'd0);
        check("rst_div_a", 64'(div_a_o), 64'd0);
        check("rst_div_b", 64'(div_b_o), 64'd0);
        check("rst_div_instr", 64'(div_instr_o), 64'(FU_NOP));
        check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        check("rst_rsp_res", 64'(rsp_res_o), 64'd0);
        check("rst_rsp_rem", 64'(rsp_rem_q_o), 64'd0);
        check("rst_rsp_err", 64'(rsp_err_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_grant", 64'(grant_idx_o), 64'd0);
        rst_n_i = 1'b1;
        tick();

        // Fairness: all four hold valid; order 0,1,2,3,0,1,2,3 with wrap
        req_valid_i = 4'b1111;
        for (int k = 0; k < 8; k++)
            do_div(k % 4, 32'(100 + 10 * (k % 4)), 32'((k % 4) + 1), 32'(k + 50), 32'(k));
        req_valid_i = 4'b0;

        // Single DIV from req1: 100 / 7 = 14 rem 2 (pointer now 0)
        req_a_i[1] = 32'd100;
        req_b_i[1] = 32'd7;
        req_valid_i = 4'b0010;
        do_div(1, 32'd100, 32'd7, 32'd14, 32'd2);
        req_valid_i = 4'b0;

        // Illegal op from req2: bypasses divider, error response next cycle
        req_instr_i[2] = FU_ACC;
        req_valid_i = 4'b0100;
        #1;
        check("ill_ready", 64'(req_ready_o), 64'b0100);
        tick();
        req_valid_i = 4'b0;
        check("ill_no_div_valid", 64'(div_valid_o), 64'd0);
        check("ill_rsp_valid", 64'(rsp_valid_o), 64'b0100);
        check("ill_res", 64'(rsp_res_o), 64'd0);
        check("ill_rem", 64'(rsp_rem_q_o), 64'd0);
        check("ill_err", 64'(rsp_err_o), 64'd1);
        rsp_ready_i = 4'b0100;
        tick();
        rsp_ready_i = 4'b0;
        req_instr_i[2] = FU_DIV;

        // Stall in IDLE: no grant while pea_ready_i low (pointer now 3)
        req_a_i[3] = 32'd55;
        req_b_i[3] = 32'd5;
        req_valid_i = 4'b1000;
        pea_ready_i = 1'b0;
        #1;
        check("stall_idle_ready", 64'(req_ready_o), 64'd0);
        tick();
        check("stall_idle_busy", 64'(busy_o), 64'd0);
        pea_ready_i = 1'b1;
        #1;
        check("unstall_ready", 64'(req_ready_o), 64'b1000);
        tick();
        req_valid_i = 4'b1111;

        // Stall in ISSUE with div_ready high
        div_ready_i = 1'b1;
        pea_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("stall_issue_valid", 64'(div_valid_o), 64'd1);
            check("stall_issue_a", 64'(div_a_o), 64'd55);
            check("stall_issue_grant", 64'(grant_idx_o), 64'd3);
            check("stall_issue_ready", 64'(req_ready_o), 64'd0);
        end
        pea_ready_i = 1'b1;
        tick();
        div_ready_i = 1'b0;
        check("after_issue_valid", 64'(div_valid_o), 64'd0);

        // Stall in WAIT with divider completion presented
        div_valid_i = 1'b1;
        div_res_i   = 32'd11;
        div_rem_q_i = 32'd0;
        pea_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("stall_wait_rsp", 64'(rsp_valid_o), 64'd0);
            check("stall_wait_busy", 64'(busy_o), 64'd1);
        end
        pea_ready_i = 1'b1;
        tick();
        div_valid_i = 1'b0;
        div_res_i   = 32'hdead;
        check("after_wait_rsp", 64'(rsp_valid_o), 64'b1000);

        // Stall in RESP with owner ready high
        rsp_ready_i = 4'b1000;
        pea_ready_i = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check("stall_rsp_valid", 64'(rsp_valid_o), 64'b1000);
            check("stall_rsp_res", 64'(rsp_res_o), 64'd11);
        end
        pea_ready_i = 1'b1;
        tick();
        rsp_ready_i = 4'b0;
        req_valid_i = 4'b0;
        check("after_rsp_busy", 64'(busy_o), 64'd0);

        // Back-pressure with REM from req0 (pointer wrapped to 0)
        req_instr_i[0] = FU_REM;
        req_a_i[0] = 32'd9;
        req_b_i[0] = 32'd4;
        req_valid_i = 4'b0001;
        #1;
        check("bp_ready", 64'(req_ready_o), 64'b0001);
        tick();
        req_valid_i = 4'b0;
        check("bp_instr", 64'(div_instr_o), 64'(FU_REM));
        div_ready_i = 1'b1;
        tick();
        div_ready_i = 1'b0;
        div_valid_i = 1'b1;
        div_res_i   = 32'd1;
        div_rem_q_i = 32'd2;
        tick();
        div_valid_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
            rsp_ready_i = (s == 2) ? 4'b0010 : 4'b0000;
            tick();
            check("bp_rsp_valid", 64'(rsp_valid_o), 64'b0001);
            check("bp_rsp_res", 64'(rsp_res_o), 64'd1);
            check("bp_rsp_rem", 64'(rsp_rem_q_o), 64'd2);
        end
        rsp_ready_i = 4'b0001;
        tick();
        rsp_ready_i = 4'b0;
        check("bp_done_busy", 64'(busy_o), 64'd0);

        // Reset mid-WAIT: req1 owns (pointer 1), then reset drops it
        req_valid_i = 4'b0011;
        #1;
        check("rw_ready", 64'(req_ready_o), 64'b0010);
        tick();
        div_ready_i = 1'b1;
        tick();
        div_ready_i = 1'b0;
        check("rw_in_wait", 64'(busy_o), 64'd1);
        rst_n_i = 1'b0;
        #1;
        check("rw_busy", 64'(busy_o), 64'd0);
        check("rw_req_ready", 64'(req_ready_o), 64'd0);
        check("rw_div_a", 64'(div_a_o), 64'd0);
        check("rw_instr", 64'(div_instr_o), 64'(FU_NOP));
        check("rw_rsp_res", 64'(rsp_res_o), 64'd0);
        check("rw_grant", 64'(grant_idx_o), 64'd0);
        #2;
        rst_n_i = 1'b1;
        #1;
        check("rw_regrant", 64'(req_ready_o), 64'b0001);
        tick();
        check("rw_owner", 64'(grant_idx_o), 64'd0);
        check("rw_owner_a", 64'(div_a_o), 64'd9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
